// File: rtl/vend_dispense_ctrl_if.sv
// Handshake bundle between the vending FSM / actuators (master side) and the
// dispense controller (slave side).
interface vend_dispense_ctrl_if #(
    parameter int QDEPTH = 4
);
    localparam int PW = $clog2(QDEPTH + 1);

    logic          x;
    logic          y;
    logic          motor_done;
    logic          coin_done;
    logic          clr_err;
    logic          motor_en;
    logic          coin_en;
    logic          busy;
    logic          ovf;
    logic          err;
    logic [PW-1:0] prod_pend;
    logic [PW-1:0] chg_pend;

    modport master (
        output x, y, motor_done, coin_done, clr_err,
        input  motor_en, coin_en, busy, ovf, err, prod_pend, chg_pend
    );

    modport slave (
        input  x, y, motor_done, coin_done, clr_err,
        output motor_en, coin_en, busy, ovf, err, prod_pend, chg_pend
    );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Queues dispense/change strobes from the vending FSM and sequences the product motor
// and coin solenoid. Define VEND_TIMEOUT_EN to add a watchdog on the done handshake.
module vend_dispense_ctrl #(
    parameter int QDEPTH    = 4,
    parameter int GAP_CYC   = 3,
    parameter int PULSE_MAX = 20
) (
    input logic                 clk,
    input logic                 rst,
    vend_dispense_ctrl_if.slave bus
);
    localparam int PW   = $clog2(QDEPTH + 1);
    localparam int TMAX = (GAP_CYC > PULSE_MAX) ? GAP_CYC : PULSE_MAX;
    localparam int TW   = $clog2(TMAX + 1);

    typedef enum logic [2:0] {IDLE, VEND, CHG, GAP, ERR} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [PW-1:0] prod_q, chg_q, prod_n, chg_n;
    logic          ovf_q, ovf_n;
    logic          motor_en_q, coin_en_q, busy_q, err_q;
    logic          motor_en_n, coin_en_n, busy_n, err_n;
    logic          prod_full, chg_full, prod_dec, chg_dec;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            prod_q     <= '0;
            chg_q      <= '0;
            ovf_q      <= 1'b0;
            motor_en_q <= 1'b0;
            coin_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            prod_q     <= prod_n;
            chg_q      <= chg_n;
            ovf_q      <= ovf_n;
            motor_en_q <= motor_en_n;
            coin_en_q  <= coin_en_n;
            busy_q     <= busy_n;
            err_q      <= err_n;
        end
    end

    // The timer restarts at zero on every state change; it counts cycles spent in
    // GAP and, in the watchdog build, cycles spent waiting for a done.
    always_comb begin
        state_n = state;
        timer_n = '0;
        case (state)
            IDLE: begin
                if (prod_q != '0)
                    state_n = VEND;
                else if (chg_q != '0)
                    state_n = CHG;
            end
            VEND: begin
                if (bus.motor_done)
                    state_n = GAP;
`ifdef VEND_TIMEOUT_EN
                else if (timer == TW'(PULSE_MAX - 1))
                    state_n = ERR;
                else
                    timer_n = timer + 1'b1;
`endif
            end
            CHG: begin
                if (bus.coin_done)
                    state_n = GAP;
`ifdef VEND_TIMEOUT_EN
                else if (timer == TW'(PULSE_MAX - 1))
                    state_n = ERR;
                else
                    timer_n = timer + 1'b1;
`endif
            end
            GAP: begin
                if (timer == TW'(GAP_CYC - 1))
                    state_n = IDLE;
                else
                    timer_n = timer + 1'b1;
            end
            ERR: begin
                if (bus.clr_err)
                    state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they change on the same edge
    // as the state. A full queue drops the strobe even if it is being serviced.
    always_comb begin
        prod_full  = (prod_q == PW'(QDEPTH));
        chg_full   = (chg_q == PW'(QDEPTH));
        prod_dec   = (state == VEND) && bus.motor_done;
        chg_dec    = (state == CHG) && bus.coin_done;
        prod_n     = prod_q + PW'(bus.x && !prod_full) - PW'(prod_dec);
        chg_n      = chg_q + PW'(bus.y && !chg_full) - PW'(chg_dec);
        ovf_n      = (ovf_q && !bus.clr_err) || (bus.x && prod_full) || (bus.y && chg_full);
        motor_en_n = (state_n == VEND);
        coin_en_n  = (state_n == CHG);
        err_n      = (state_n == ERR);
        busy_n     = (state_n != IDLE) || (prod_n != '0) || (chg_n != '0);
    end

    assign bus.motor_en  = motor_en_q;
    assign bus.coin_en   = coin_en_q;
    assign bus.busy      = busy_q;
    assign bus.ovf       = ovf_q;
    assign bus.err       = err_q;
    assign bus.prod_pend = prod_q;
    assign bus.chg_pend  = chg_q;
endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Self-checking bench for vend_dispense_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a behavioural model.
module tb_vend_dispense_ctrl;
    localparam int QDEPTH    = 4;
    localparam int GAP_CYC   = 3;
    localparam int PULSE_MAX = 20;
`ifdef VEND_TIMEOUT_EN
    localparam bit TMO = 1'b1;
`else
    localparam bit TMO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    bit   cmp_on = 1'b0;
    int   cnt, first_m, first_c;

    // Model: counts of pending requests, which actuator is on (0 none, 1 motor,
    // 2 coin), how long it has been on, remaining gap cycles, and the error flag.
    int   m_prod, m_chg, m_act, m_on, m_gap;
    bit   m_ovf, m_err;

    vend_dispense_ctrl_if #(.QDEPTH(QDEPTH)) vif ();

    vend_dispense_ctrl #(
        .QDEPTH   (QDEPTH),
        .GAP_CYC  (GAP_CYC),
        .PULSE_MAX(PULSE_MAX)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(vif)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic ix, input logic iy, input logic imd,
                                 input logic icd, input logic iclr);
        vif.x          = ix;
        vif.y          = iy;
        vif.motor_done = imd;
        vif.coin_done  = icd;
        vif.clr_err    = iclr;
    endtask

    task automatic compareVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset;
        m_prod = 0; m_chg = 0; m_act = 0; m_on = 0; m_gap = 0;
        m_ovf  = 1'b0; m_err = 1'b0;
    endtask

    task automatic modelStep;
        bit full_p, full_c, pdec, cdec;
        full_p = (m_prod == QDEPTH);
        full_c = (m_chg == QDEPTH);
        pdec   = (m_act == 1) && vif.motor_done;
        cdec   = (m_act == 2) && vif.coin_done;
        m_ovf  = (m_ovf && !vif.clr_err) || (vif.x && full_p) || (vif.y && full_c);
        if (m_err) begin
            if (vif.clr_err) m_err = 1'b0;
        end else if (m_act != 0) begin
            if (pdec || cdec) begin
                m_act = 0;
                m_gap = GAP_CYC;
            end else if (TMO && m_on == PULSE_MAX) begin
                m_act = 0;
                m_err = 1'b1;
            end else begin
                m_on++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (m_prod > 0) begin
            m_act = 1;
            m_on  = 1;
        end else if (m_chg > 0) begin
            m_act = 2;
            m_on  = 1;
        end
        m_prod = m_prod + ((vif.x && !full_p) ? 1 : 0) - (pdec ? 1 : 0);
        m_chg  = m_chg + ((vif.y && !full_c) ? 1 : 0) - (cdec ? 1 : 0);
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) modelReset();
        else modelStep();
    end

    task automatic checkOutput;
        compareVal("motor_en", vif.motor_en, (m_act == 1) ? 1 : 0);
        compareVal("coin_en", vif.coin_en, (m_act == 2) ? 1 : 0);
        compareVal("both_en", vif.motor_en & vif.coin_en, 0);
        compareVal("err", vif.err, m_err);
        compareVal("ovf", vif.ovf, m_ovf);
        compareVal("prod_pend", vif.prod_pend, m_prod);
        compareVal("chg_pend", vif.chg_pend, m_chg);
        compareVal("busy", vif.busy,
                   (m_act != 0 || m_gap > 0 || m_err || m_prod > 0 || m_chg > 0) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        if (cmp_on && !rst) checkOutput();
    end

    task automatic waitIdle(input string name, input int limit);
        for (int i = 0; i < limit && vif.busy; i++) tick();
        compareVal(name, vif.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        modelReset();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        cmp_on = 1'b1;

        // Reset state
        compareVal("rst_motor_en", vif.motor_en, 0);
        compareVal("rst_coin_en", vif.coin_en, 0);
        compareVal("rst_busy", vif.busy, 0);
        compareVal("rst_ovf", vif.ovf, 0);
        compareVal("rst_err", vif.err, 0);
        compareVal("rst_prod_pend", vif.prod_pend, 0);
        compareVal("rst_chg_pend", vif.chg_pend, 0);

        // Single dispense, done on the fifth motor cycle
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        compareVal("t2_prod_pend_after_x", vif.prod_pend, 1);
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        compareVal("t2_motor_rise", vif.motor_en, 1);
        cnt = 0;
        for (int i = 0; i < 50 && vif.motor_en; i++) begin
            cnt++;
            applyStimulus(0, 0, cnt == 5, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0);
        compareVal("t2_motor_cycles", cnt, 5);
        compareVal("t2_prod_pend_done", vif.prod_pend, 0);
        compareVal("t2_busy_in_gap", vif.busy, 1);
        repeat (GAP_CYC - 1) tick();
        compareVal("t2_busy_gap_end", vif.busy, 1);
        tick();
        compareVal("t2_busy_idle", vif.busy, 0);

        // Simultaneous x and y, done held high so each actuation lasts one cycle
        applyStimulus(1, 1, 1, 1, 0);
        first_m = -1;
        first_c = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (i == 1) applyStimulus(0, 0, 1, 1, 0);
            if (vif.motor_en && first_m < 0) first_m = i;
            if (vif.coin_en && first_c < 0) first_c = i;
        end
        applyStimulus(0, 0, 0, 0, 0);
        compareVal("t3_motor_first", first_m, 2);
        compareVal("t3_coin_first", first_c, 7);

        // Overflow of the product queue, then clr_err outside ERR
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 0, 0, 0);
            tick();
        end
        applyStimulus(0, 0, 0, 0, 0);
        compareVal("t4_prod_pend_full", vif.prod_pend, 4);
        compareVal("t4_ovf_set", vif.ovf, 1);
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        compareVal("t4_ovf_cleared", vif.ovf, 0);
        compareVal("t4_prod_pend_kept", vif.prod_pend, 4);
        applyStimulus(0, 0, 1, 1, 0);
        waitIdle("t4_drain", 400);
        applyStimulus(0, 0, 0, 0, 0);
        tick();

`ifdef VEND_TIMEOUT_EN
        // Watchdog expiry and retry
        applyStimulus(1, 0, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        cnt = 0;
        for (int i = 0; i < 100 && vif.motor_en; i++) begin
            cnt++;
            tick();
        end
        compareVal("t5_vend_cycles", cnt, 20);
        compareVal("t5_err", vif.err, 1);
        compareVal("t5_motor_off", vif.motor_en, 0);
        compareVal("t5_prod_pend", vif.prod_pend, 1);
        applyStimulus(0, 0, 0, 0, 1);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        compareVal("t5_err_cleared", vif.err, 0);
        tick();
        compareVal("t5_retry", vif.motor_en, 1);
        applyStimulus(0, 0, 1, 1, 0);
        waitIdle("t5_drain", 100);
        applyStimulus(0, 0, 0, 0, 0);
        tick();
`endif

        // Asynchronous reset in the middle of a dispense
        applyStimulus(1, 1, 0, 0, 0);
        tick();
        applyStimulus(0, 0, 0, 0, 0);
        tick();
        compareVal("t6_in_vend", vif.motor_en, 1);
        #2 rst = 1'b1;
        #1;
        compareVal("t6_async_motor_en", vif.motor_en, 0);
        compareVal("t6_async_prod_pend", vif.prod_pend, 0);
        compareVal("t6_async_chg_pend", vif.chg_pend, 0);
        compareVal("t6_async_busy", vif.busy, 0);
        tick();
        #3 rst = 1'b0;
        tick();
        compareVal("t6_idle_after_rst", vif.busy, 0);

        // Randomized traffic; the compare process checks every cycle
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 12,
                          $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 30,
                          $urandom_range(0, 99) < 3);
            tick();
        end
        applyStimulus(0, 0, 1, 1, 1);
        tick();
        applyStimulus(0, 0, 1, 1, 0);
        waitIdle("rand_drain", 400);
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) tick();

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
